// File: rtl/btn_conditioner.sv
// Push-button front end: 2-flop synchroniser, per-bit debounce, press/release
// pulses and a latched one-hot operation select for the calculator.
module btn_conditioner #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic             op_clr,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] op_sel
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0] sync_s1;
    logic [N_BTN-1:0] sync_s2;
    logic [CNT_W-1:0] cnt      [N_BTN];
    logic [CNT_W-1:0] cnt_next [N_BTN];
    logic [N_BTN-1:0] flip;
    logic [N_BTN-1:0] op_sel_next;
    logic             multi_press;
    logic             chord;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, exactly like hardware.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_s1 <= '0;
            sync_s2 <= '0;
        end else begin
            sync_s1 <= btn_raw;
            sync_s2 <= sync_s1;
        end
    end

    // A bit flips once its synchronised input has disagreed with the accepted
    // level for DEBOUNCE_CYCLES consecutive edges; any agreement restarts.
    always_comb begin
        // NOTE: defaults first, so no path through the loop leaves a variable
        // unassigned and infers a latch.
        flip = '0;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_next[i] = '0;
            if (sync_s2[i] != btn_level[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    flip[i] = 1'b1;
                end else begin
                    cnt_next[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    // NOTE: the counter array is a bank of real flops, not a RAM, so it is
    // cleared by reset like any other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_BTN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
        end else begin
            btn_level   <= btn_level ^ flip;
            btn_press   <= flip & ~btn_level;
            btn_release <= flip & btn_level;
        end
    end

    // The registered press pulse is judged against the level already showing
    // it, so "other bits held" means level bits outside the pressed one.
    always_comb begin
        multi_press = |(btn_press & (btn_press - N_BTN'(1)));
        chord       = |(btn_level & ~btn_press);
        op_sel_next = op_sel;
        if (op_clr) begin
            op_sel_next = '0;
        end else if (multi_press) begin
            op_sel_next = '0;
        end else if (|btn_press) begin
            if (chord) begin
                op_sel_next = '0;
            end else if (op_sel == btn_press) begin
                op_sel_next = '0;
            end else begin
                op_sel_next = btn_press;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_sel <= '0;
        end else begin
            op_sel <= op_sel_next;
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner: directed scenarios with literal
// expectations plus randomised buttons compared every cycle against a model.
module tb_btn_conditioner;

    localparam int N   = 4;
    localparam int D   = 4;
    localparam int CW  = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn_raw;
    logic         op_clr;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic [N-1:0] op_sel;

    int total = 0;
    int bad   = 0;

    btn_conditioner #(
        .N_BTN          (N),
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .op_clr     (op_clr),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .op_sel     (op_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: the input seen by the debouncer is the raw sample from
    // two edges ago; a bit changes level when the last D such samples all
    // disagree with the current level.
    bit [N-1:0] u_prev1, u_prev2;
    bit [N-1:0] win[$];
    bit [N-1:0] m_level, m_press, m_release, m_op;
    bit         started = 1'b0;

    always @(posedge clk) begin
        bit [N-1:0] s2v, flips, nxt_op;
        bit         all_diff;
        if (rst) begin
            u_prev1   = '0;
            u_prev2   = '0;
            win.delete();
            for (int j = 0; j < D; j++) win.push_back('0);
            m_level   = '0;
            m_press   = '0;
            m_release = '0;
            m_op      = '0;
        end else begin
            nxt_op = m_op;
            if (op_clr)                        nxt_op = '0;
            else if ($countones(m_press) > 1)  nxt_op = '0;
            else if ($countones(m_press) == 1) begin
                if ((m_level & ~m_press) != 0) nxt_op = '0;
                else if (m_op == m_press)      nxt_op = '0;
                else                           nxt_op = m_press;
            end
            s2v = u_prev2;
            win.push_back(s2v);
            void'(win.pop_front());
            flips = '0;
            for (int i = 0; i < N; i++) begin
                all_diff = 1'b1;
                foreach (win[j]) if (win[j][i] == m_level[i]) all_diff = 1'b0;
                flips[i] = all_diff;
            end
            m_press   = flips & ~m_level;
            m_release = flips & m_level;
            m_level   = m_level ^ flips;
            m_op      = nxt_op;
            u_prev2   = u_prev1;
            u_prev1   = btn_raw;
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            check("level",   32'(btn_level),   32'(m_level));
            check("press",   32'(btn_press),   32'(m_press));
            check("release", 32'(btn_release), 32'(m_release));
            check("op_sel",  32'(op_sel),      32'(m_op));
        end
    end

    initial begin
        int rst_left;
        rst     = 1'b1;
        btn_raw = '0;
        op_clr  = 1'b0;
        cyc(3);
        rst = 1'b0;
        cyc(10);
        check("idle_level", 32'(btn_level), 32'h0);
        check("idle_op",    32'(op_sel),    32'h0);

        // Clean step on btn0.
        btn_raw[0] = 1'b1;
        cyc(5);
        check("step_level_early", 32'(btn_level), 32'h0);
        cyc(1);
        check("step_level", 32'(btn_level), 32'h1);
        check("step_press", 32'(btn_press), 32'h1);
        check("step_op_pre", 32'(op_sel),   32'h0);
        cyc(1);
        check("step_press_end", 32'(btn_press), 32'h0);
        check("step_op",        32'(op_sel),    32'h1);
        btn_raw[0] = 1'b0;
        cyc(8);
        check("release_keeps_op", 32'(op_sel), 32'h1);

        // Bounce on btn1, then steady high.
        for (int k = 0; k < 5; k++) begin
            btn_raw[1] = ((k % 2) == 0);
            cyc(1);
            check("bounce_no_press", 32'(btn_press), 32'h0);
        end
        cyc(4);
        check("bounce_press_early", 32'(btn_press), 32'h0);
        cyc(1);
        check("bounce_press", 32'(btn_press), 32'h2);
        cyc(1);
        check("bounce_op", 32'(op_sel), 32'h2);

        // Chord and toggle.
        btn_raw[1] = 1'b0; cyc(8);
        btn_raw[0] = 1'b1; cyc(8);
        check("chord_setup", 32'(op_sel), 32'h1);
        btn_raw[2] = 1'b1; cyc(8);
        check("chord_clear", 32'(op_sel), 32'h0);
        btn_raw = '0;      cyc(8);
        btn_raw[2] = 1'b1; cyc(8);
        check("select_2", 32'(op_sel), 32'h4);
        btn_raw[2] = 1'b0; cyc(8);
        btn_raw[2] = 1'b1; cyc(8);
        check("toggle_off", 32'(op_sel), 32'h0);
        btn_raw = '0;      cyc(8);

        // op_clr wins over a simultaneous press.
        btn_raw[2] = 1'b1; cyc(8);
        check("clr_setup", 32'(op_sel), 32'h4);
        btn_raw[2] = 1'b0; cyc(8);
        btn_raw[3] = 1'b1; cyc(6);
        check("clr_press3", 32'(btn_press), 32'h8);
        op_clr = 1'b1; cyc(1);
        op_clr = 1'b0;
        check("clr_wins", 32'(op_sel), 32'h0);
        btn_raw = '0; cyc(8);

        // Simultaneous presses.
        btn_raw[0] = 1'b1; cyc(8);
        btn_raw[0] = 1'b0; cyc(8);
        check("multi_setup", 32'(op_sel), 32'h1);
        btn_raw = 4'b1010; cyc(6);
        check("multi_press", 32'(btn_press), 32'ha);
        cyc(1);
        check("multi_op", 32'(op_sel), 32'h0);
        btn_raw = '0; cyc(8);

        // Reset mid-count with btn0 held.
        btn_raw[0] = 1'b1; cyc(3);
        rst = 1'b1; cyc(2);
        check("rst_level", 32'(btn_level), 32'h0);
        check("rst_press", 32'(btn_press), 32'h0);
        check("rst_op",    32'(op_sel),    32'h0);
        rst = 1'b0; cyc(5);
        check("rst_level_early", 32'(btn_level), 32'h0);
        cyc(1);
        check("rst_press_after", 32'(btn_press), 32'h1);
        check("rst_level_after", 32'(btn_level), 32'h1);
        cyc(1);
        check("rst_op_after", 32'(op_sel), 32'h1);
        btn_raw = '0; cyc(8);

        // Randomised buttons, op_clr and occasional resets.
        rst_left = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0) btn_raw[i] = ~btn_raw[i];
            end
            op_clr = ($urandom_range(0, 39) == 0);
            if (rst_left > 0) begin
                rst_left--;
            end else if ($urandom_range(0, 499) == 0) begin
                rst_left = int'($urandom_range(1, 3));
            end
            rst = (rst_left > 0);
            cyc(1);
        end
        rst    = 1'b0;
        op_clr = 1'b0;
        btn_raw = '0;
        cyc(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
